// File: rtl/ir_freq_meter.sv
// ir_freq_meter: multi-channel IR beacon frequency meter counting rising edges over a common gate window.
// Ports: clk, reset (sync, active-high), enable (run windows continuously), isig[CHANNELS] (async IR inputs),
//        freq[CHANNELS*CNT_W] (latched counts, ch i at [i*CNT_W +: CNT_W]), done (1-cycle update strobe),
//        overflow[CHANNELS] (count saturated last window), in_band[CHANNELS] (BAND_LO <= count <= BAND_HI).
// Build option: define IR_FREQ_BAND_EN to compile in the band comparators; otherwise in_band is tied to 0.
module ir_freq_meter #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 32,
  parameter int GATE_CYCLES = 50_000_000,
  parameter int SYNC_STAGES = 2,
  parameter int BAND_LO     = 900,
  parameter int BAND_HI     = 1100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       isig,
  output logic [CHANNELS*CNT_W-1:0] freq,
  output logic                      done,
  output logic [CHANNELS-1:0]       overflow,
  output logic [CHANNELS-1:0]       in_band
);
  // The gate counter is never narrower than CNT_W; it widens only if the window length needs more bits.
  localparam int GATE_W = (CNT_W > $clog2(GATE_CYCLES + 1)) ? CNT_W : $clog2(GATE_CYCLES + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GATE  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CHANNELS-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CHANNELS-1:0] hist_q, hist_d, rise;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d, freq_q, freq_d;
  logic done_q, done_d;
  logic [CHANNELS-1:0] ovf_q, ovf_d;
`ifdef IR_FREQ_BAND_EN
  localparam logic [CNT_W-1:0] LO = CNT_W'(BAND_LO);
  localparam logic [CNT_W-1:0] HI = CNT_W'(BAND_HI);
  logic [CHANNELS-1:0] band_q, band_d;
`endif
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    freq_d  = freq_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
`ifdef IR_FREQ_BAND_EN
    band_d  = band_q;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], isig[i]};
      hist_d[i] = sync_q[i][SYNC_STAGES-1];
      rise[i]   = sync_q[i][SYNC_STAGES-1] & ~hist_q[i];
    end
    if (state_q == IDLE) begin
      gate_d  = '0;
      cnt_d   = '0;
      state_d = enable ? GATE : IDLE;
    end else if (state_q == GATE) begin
      if (!enable) begin
        // Abort: drop the partial window, outputs keep their last latched values.
        gate_d  = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        gate_d = gate_q + 1'b1;
        for (int i = 0; i < CHANNELS; i++)
          cnt_d[i] = (rise[i] && cnt_q[i] != CNT_MAX) ? cnt_q[i] + 1'b1 : cnt_q[i];
        state_d = (gate_q == GATE_LAST) ? LATCH : GATE;
      end
    end else if (state_q == LATCH) begin
      // Edges seen in this cycle are intentionally discarded by the counter clear.
      freq_d = cnt_q;
      done_d = 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        ovf_d[i] = cnt_q[i] == CNT_MAX;
`ifdef IR_FREQ_BAND_EN
        band_d[i] = cnt_q[i] >= LO && cnt_q[i] <= HI;
`endif
      end
      gate_d  = '0;
      cnt_d   = '0;
      state_d = enable ? GATE : IDLE;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gate_q  <= '0;
      sync_q  <= '0;
      hist_q  <= '0;
      cnt_q   <= '0;
      freq_q  <= '0;
      done_q  <= 1'b0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end
`ifdef IR_FREQ_BAND_EN
  always_ff @(posedge clk) begin
    if (reset) band_q <= '0;
    else band_q <= band_d;
  end
  assign in_band = band_q;
`else
  assign in_band = '0;
`endif
  assign freq     = freq_q;
  assign done     = done_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_ir_freq_meter.sv
// tb_ir_freq_meter: directed bench for ir_freq_meter (16-bit counts plus an 8-bit instance for saturation).
module tb_ir_freq_meter;
`ifdef IR_FREQ_BAND_EN
  localparam bit BAND = 1'b1;
`else
  localparam bit BAND = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic [3:0] bsig = '0, bsig8 = '0, sq, isig, isig8;
  logic sq_en = 1'b0, tog_en = 1'b0, t = 1'b0;
  int ph = 0;
  logic [63:0] freq;
  logic [31:0] freq8;
  logic done, done8;
  logic [3:0] ovf, ovf8, band, band8;
  int vectors = 0, errs = 0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    ph <= ph + 1;
    t  <= ~t;
  end
  assign sq    = {2'b00, (ph % 20) < 10, (ph % 10) < 5};
  assign isig  = sq_en ? sq : bsig;
  assign isig8 = tog_en ? {3'b000, t} : bsig8;
  ir_freq_meter #(.CHANNELS(4), .CNT_W(16), .GATE_CYCLES(1000), .SYNC_STAGES(2), .BAND_LO(90), .BAND_HI(110)) dut (
    .clk(clk), .reset(reset), .enable(enable), .isig(isig),
    .freq(freq), .done(done), .overflow(ovf), .in_band(band)
  );
  ir_freq_meter #(.CHANNELS(4), .CNT_W(8), .GATE_CYCLES(1000), .SYNC_STAGES(2), .BAND_LO(90), .BAND_HI(110)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .isig(isig8),
    .freq(freq8), .done(done8), .overflow(ovf8), .in_band(band8)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic wait_done(input string tag, input int exp_cyc);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < 3000);
    if (exp_cyc > 0) chk(tag, 64'(c), 64'(exp_cyc));
    else chk(tag, {63'd0, done}, 64'd1);
  endtask
  task automatic burst(input int n0, input int n1, input int n2, input int n3, input int m0);
    for (int k = 0; k < 112; k++) begin
      bsig  = {k < n3, k < n2, k < n1, k < n0};
      bsig8 = {3'b000, k < m0};
      repeat (2) @(negedge clk);
      bsig  = '0;
      bsig8 = '0;
      repeat (2) @(negedge clk);
    end
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_freq", freq, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_band", 64'(band), 64'd0);
    chk("rst_freq8", 64'(freq8), 64'd0);
    reset  = 1'b0;
    sq_en  = 1'b1;
    enable = 1'b1;
    wait_done("first_done", 1002);
    wait_done("period", 1001);
    chk("sq_freq", freq, 64'h0000_0000_0032_0064);
    chk("sq_ovf", 64'(ovf), 64'd0);
    chk("sq_band", 64'(band), BAND ? 64'd1 : 64'd0);
    @(negedge clk);
    chk("done_width", {63'd0, done}, 64'd0);
    sq_en = 1'b0;
    wait_done("band_pre", 0);
    burst(95, 111, 90, 0, 0);
    wait_done("band_win", 0);
    chk("band_freq", freq, 64'h0000_005A_006F_005F);
    chk("band_flags", 64'(band), BAND ? 64'h5 : 64'd0);
    repeat (500) @(negedge clk);
    enable = 1'b0;
    n = 0;
    for (int k = 0; k < 1100; k++) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_nodone", 64'(n), 64'd0);
    chk("abort_freq", freq, 64'h0000_005A_006F_005F);
    chk("abort_idle", 64'(dut.state_q), 64'd0);
    enable = 1'b1;
    wait_done("reenable", 1002);
    chk("reenable_freq", freq, 64'd0);
    burst(3, 4, 5, 6, 0);
    wait_done("pre_reset", 0);
    chk("pre_reset_freq", freq, 64'h0006_0005_0004_0003);
    repeat (300) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_freq", freq, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    chk("mid_rst_band", 64'(band), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_done("post_reset", 1002);
    chk("post_reset_freq", freq, 64'd0);
    repeat (996) @(negedge clk);
    bsig[2] = 1'b1;
    @(negedge clk);
    bsig[0] = 1'b1;
    @(negedge clk);
    bsig[1] = 1'b1;
    @(negedge clk);
    bsig[3] = 1'b1;
    wait_done("bnd_done", 2);
    chk("bnd_freq", freq, 64'h0000_0001_0000_0001);
    bsig = '0;
    wait_done("bnd_next", 0);
    chk("bnd_next_freq", freq, 64'h0001_0000_0000_0000);
    tog_en = 1'b1;
    wait_done("ovf_win", 0);
    chk("ovf_freq8", 64'(freq8), 64'h0000_00FF);
    chk("ovf_flag8", 64'(ovf8), 64'h1);
    tog_en = 1'b0;
    wait_done("ovf_gap", 0);
    burst(0, 0, 0, 0, 100);
    wait_done("ovf_clr", 0);
    chk("clr_freq8", 64'(freq8), 64'h0000_0064);
    chk("clr_flag8", 64'(ovf8), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/ir_freq_meter.md
# ir_freq_meter

Multi-channel, parametrised IR beacon frequency meter for the rover's sensor front end. Counts rising edges on each asynchronous IR receiver input over a common, programmable gate window and publishes one count per channel with a single-cycle `done` strobe. Optional band classification flags channels whose count lies inside a configured beacon band. The result feeds the navigation FSM, which picks beacon direction from per-channel counts.

## Interface
Parameters:
- `CHANNELS`, 4: number of IR inputs, at least 1.
- `CNT_W`, 32: width of each per-channel count and of the gate counter.
- `GATE_CYCLES`, 50_000_000: gate window length in `clk` cycles; 1 s at 50 MHz, so a count equals Hz. Range 2..2^CNT_W-1.
- `SYNC_STAGES`, 2: synchroniser flops per input, at least 2.
- `BAND_LO`, 900: inclusive lower band bound in counts. Used only with `IR_FREQ_BAND_EN`.
- `BAND_HI`, 1100: inclusive upper band bound in counts. Used only with `IR_FREQ_BAND_EN`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run measurement windows continuously while high.
- `isig`  in  CHANNELS  asynchronous IR receiver outputs.
- `freq`  out  CHANNELS*CNT_W  latched counts; channel i is at `[i*CNT_W +: CNT_W]`.
- `done`  out  1  one-cycle strobe: `freq` was just updated.
- `overflow`  out  CHANNELS  latched per channel: the count saturated in the last window.
- `in_band`  out  CHANNELS  latched per channel: `BAND_LO <= count <= BAND_HI`.

## Operation
- Each `isig[i]` passes through a `SYNC_STAGES` flop chain, then one history flop. A rising edge is synchronised=1 with history=0. Only rising edges are counted.
- FSM states:
  - IDLE: gate counter and edge counters held at 0. Go to GATE when `enable`=1.
  - GATE: gate counter increments every cycle; each channel's edge counter increments on a rising edge. At gate counter = `GATE_CYCLES-1`, go to LATCH.
  - LATCH: load `freq`, `overflow`, and `in_band`; pulse `done`; clear the gate counter and edge counters. Go to GATE if `enable`=1, otherwise IDLE.
- An edge detected on the cycle the gate counter equals `GATE_CYCLES-1` counts in the current window. An edge detected during the LATCH cycle is dropped.
- Edge counters saturate at 2^CNT_W-1, and saturation sets that channel's `overflow` bit at latch.
- `enable` falling during GATE aborts the window:
  - go to IDLE next cycle and clear the counters;
  - `done` does not pulse;
  - `freq`, `overflow`, and `in_band` keep their previous values.
- Reset, at any point including mid-window, gives:
  - state IDLE;
  - all counters, synchroniser flops, and history flops at 0;
  - `freq`=0, `done`=0, `overflow`=0, `in_band`=0.
- Reset has priority over `enable`.

## Timing
- Edge-to-count latency: `SYNC_STAGES`+1 cycles from `isig` sampling to the edge-counter increment.
- Window period: `GATE_CYCLES`+1 cycles (GATE cycles plus one LATCH cycle) while `enable` is held high.
- `freq`, `overflow`, and `in_band` change only in the cycle `done`=1, i.e. the cycle after LATCH is entered; registered outputs. They are stable between strobes.
- First `done` occurs `GATE_CYCLES`+2 cycles after `enable` rises from IDLE.
- Input pulses must be at least 1 clk high and 1 clk low to be counted. Narrower pulses may be missed.

## Configuration
- `IR_FREQ_BAND_EN` defined: band comparators are compiled in, and `in_band` is updated at each latch as specified.
- `IR_FREQ_BAND_EN` undefined: no comparators; `in_band` is tied to 0 and `BAND_LO`/`BAND_HI` are ignored. All other behaviour is identical.

## Test plan
Bench uses `GATE_CYCLES`=1000, `CHANNELS`=4, `CNT_W`=16, `BAND_LO`=90, `BAND_HI`=110.
- Square wave of period 10 clk on ch0 and period 20 on ch1; ch2 and ch3 idle; `enable`=1 → after the second window, `freq`={0,0,50,100} (ch3..ch0) and `done` high exactly 1 cycle per 1001.
- Per-channel rates 95, 111, and 90 edges per window with `IR_FREQ_BAND_EN` → `in_band` ch0=1, ch1=0, ch2=1. Without the macro, `in_band`=0.
- `enable` dropped at gate cycle 500 → no `done`, `freq` unchanged, FSM in IDLE. Re-enable → first `done` 1002 cycles later.
- Reset asserted mid-window with `freq` non-zero → next cycle all outputs 0. No `done` until a full window completes after reset release.
- `CNT_W`=8 with ch0 toggling every clk (500 edges) → `freq` ch0=255, `overflow[0]`=1. Next window at 100 edges → `freq`=100, `overflow[0]`=0.
- Rising edge timed to be detected at gate count 999 → counted in that window. Edge detected during LATCH → not counted in either window.
